// File: rtl/addr_count_gen.sv
// Four-channel DMA address/count generator: CPU-programmed base/current registers,
// a working address/count pair that steps once per transfer, and sticky terminal-count flags.
module addr_count_gen (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       CS_N,
    input  logic       IOW_N,
    input  logic [3:0] A_in,
    input  logic [7:0] DB_in,
    input  logic [1:0] ActiveChannel,
    input  logic       ldTempAddr,
    input  logic       AddrGen,
    input  logic       enAddrUp,
    input  logic       enAddrLo,
    input  logic [3:0] AddrDec,
    input  logic [3:0] AutoInit,
    output logic [7:0] UpperAddr,
    output logic [7:0] LowerAddr,
    output logic       TC,
    output logic       Carry,
    output logic [3:0] TCStatus
);

    logic [15:0] base_addr  [4];
    logic [15:0] base_count [4];
    logic [15:0] curr_addr  [4];
    logic [15:0] curr_count [4];
    logic [15:0] temp_addr;
    logic [15:0] temp_count;
    logic [1:0]  temp_ch;
    logic        temp_valid;
    logic        bpff;
    logic        iow_prev;

    logic        cpu_wr;
    logic        master_clr;
    logic        reg_wr;
    logic [1:0]  wr_ch;
    logic        write_back_ok;
    logic [15:0] next_addr;
    logic [15:0] next_count;

    always_comb begin
        cpu_wr        = !CS_N && !IOW_N && iow_prev;
        master_clr    = cpu_wr && (A_in == 4'hD);
        reg_wr        = cpu_wr && !A_in[3];
        wr_ch         = A_in[2:1];
        // A CPU write to the channel being serviced wins over its write-back
        write_back_ok = !(reg_wr && (wr_ch == temp_ch));
        next_addr     = AddrDec[temp_ch] ? (temp_addr - 16'd1) : (temp_addr + 16'd1);
        next_count    = temp_count - 16'd1;
        TC            = temp_valid && (temp_count == 16'h0000);
        Carry         = temp_valid &&
                        ((!AddrDec[temp_ch] && (temp_addr[7:0] == 8'hFF)) ||
                         ( AddrDec[temp_ch] && (temp_addr[7:0] == 8'h00)));
    end

    // Strobe edge detector: held-low IOW_N produces exactly one write
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            iow_prev <= 1'b1;
        end else begin
            iow_prev <= IOW_N;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET || master_clr) begin
            for (int i = 0; i < 4; i++) begin
                base_addr[i]  <= 16'h0000;
                base_count[i] <= 16'h0000;
                curr_addr[i]  <= 16'h0000;
                curr_count[i] <= 16'h0000;
            end
            temp_addr  <= 16'h0000;
            temp_count <= 16'h0000;
            temp_ch    <= 2'd0;
            temp_valid <= 1'b0;
            bpff       <= 1'b0;
            UpperAddr  <= 8'h00;
            LowerAddr  <= 8'h00;
            TCStatus   <= 4'h0;
        end else begin
            if (enAddrUp) begin
                UpperAddr <= temp_addr[15:8];
            end
            if (enAddrLo) begin
                LowerAddr <= temp_addr[7:0];
            end

            if (ldTempAddr) begin
                temp_addr  <= curr_addr[ActiveChannel];
                temp_count <= curr_count[ActiveChannel];
                temp_ch    <= ActiveChannel;
                temp_valid <= 1'b1;
            end else if (AddrGen) begin
                temp_addr  <= next_addr;
                temp_count <= next_count;
                if (write_back_ok) begin
                    if (TC && AutoInit[temp_ch]) begin
                        curr_addr[temp_ch]  <= base_addr[temp_ch];
                        curr_count[temp_ch] <= base_count[temp_ch];
                    end else begin
                        curr_addr[temp_ch]  <= next_addr;
                        curr_count[temp_ch] <= next_count;
                    end
                end
                if (TC) begin
                    TCStatus[temp_ch] <= 1'b1;
                    temp_valid        <= 1'b0;
                end
            end

            // Register writes come last so a count write's TC clear overrides a same-cycle set
            if (reg_wr) begin
                if (A_in[0]) begin
                    if (bpff) begin
                        base_count[wr_ch][15:8] <= DB_in;
                        curr_count[wr_ch][15:8] <= DB_in;
                    end else begin
                        base_count[wr_ch][7:0] <= DB_in;
                        curr_count[wr_ch][7:0] <= DB_in;
                    end
                    TCStatus[wr_ch] <= 1'b0;
                end else begin
                    if (bpff) begin
                        base_addr[wr_ch][15:8] <= DB_in;
                        curr_addr[wr_ch][15:8] <= DB_in;
                    end else begin
                        base_addr[wr_ch][7:0] <= DB_in;
                        curr_addr[wr_ch][7:0] <= DB_in;
                    end
                end
                bpff <= ~bpff;
            end else if (cpu_wr && (A_in == 4'hC)) begin
                bpff <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_addr_count_gen.sv
// Bench for addr_count_gen: directed scenarios plus a random phase, all checked
// against an arithmetic reference model of the channel registers.
module tb_addr_count_gen;

    logic       CLOCK = 1'b0;
    logic       RESET;
    logic       CS_N;
    logic       IOW_N;
    logic [3:0] A_in;
    logic [7:0] DB_in;
    logic [1:0] ActiveChannel;
    logic       ldTempAddr;
    logic       AddrGen;
    logic       enAddrUp;
    logic       enAddrLo;
    logic [3:0] AddrDec;
    logic [3:0] AutoInit;
    logic [7:0] UpperAddr;
    logic [7:0] LowerAddr;
    logic       TC;
    logic       Carry;
    logic [3:0] TCStatus;

    int pass_count  = 0;
    int fail_count  = 0;
    int check_count = 0;

    int m_base_addr[4];
    int m_base_count[4];
    int m_curr_addr[4];
    int m_curr_count[4];
    int m_temp_addr;
    int m_temp_count;
    int m_temp_ch;
    bit m_temp_valid;
    bit m_bpff;
    bit m_prev_iow = 1'b1;
    int m_upper;
    int m_lower;
    bit [3:0] m_tcs;

    always #5 CLOCK = ~CLOCK;

    addr_count_gen dut (
        .CLOCK(CLOCK), .RESET(RESET), .CS_N(CS_N), .IOW_N(IOW_N),
        .A_in(A_in), .DB_in(DB_in), .ActiveChannel(ActiveChannel),
        .ldTempAddr(ldTempAddr), .AddrGen(AddrGen),
        .enAddrUp(enAddrUp), .enAddrLo(enAddrLo),
        .AddrDec(AddrDec), .AutoInit(AutoInit),
        .UpperAddr(UpperAddr), .LowerAddr(LowerAddr),
        .TC(TC), .Carry(Carry), .TCStatus(TCStatus)
    );

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        check_count++;
        assert (obs === exp) pass_count++;
        else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            m_base_addr[i] = 0; m_base_count[i] = 0;
            m_curr_addr[i] = 0; m_curr_count[i] = 0;
        end
        m_temp_addr = 0; m_temp_count = 0; m_temp_ch = 0; m_temp_valid = 0;
        m_bpff = 0; m_upper = 0; m_lower = 0; m_tcs = 4'h0;
    endtask

    // One clock of the reference model, driven by the inputs currently applied
    task automatic model_step();
        bit wr;
        bit tc_now;
        int ch;
        int cpu_ch;
        int shift;
        int mask;
        int old_taddr;
        wr = !RESET && !CS_N && !IOW_N && m_prev_iow;
        old_taddr = m_temp_addr;
        if (RESET || (wr && A_in == 4'hD)) begin
            model_clear();
        end else begin
            if (enAddrUp) m_upper = old_taddr / 256;
            if (enAddrLo) m_lower = old_taddr % 256;
            cpu_ch = (wr && A_in < 8) ? int'(A_in) / 2 : -1;
            if (ldTempAddr) begin
                ch = int'(ActiveChannel);
                m_temp_addr  = m_curr_addr[ch];
                m_temp_count = m_curr_count[ch];
                m_temp_ch    = ch;
                m_temp_valid = 1;
            end else if (AddrGen) begin
                ch = m_temp_ch;
                tc_now = m_temp_valid && (m_temp_count == 0);
                m_temp_addr  = AddrDec[ch] ? (m_temp_addr + 65535) % 65536 : (m_temp_addr + 1) % 65536;
                m_temp_count = (m_temp_count + 65535) % 65536;
                if (cpu_ch != ch) begin
                    if (tc_now && AutoInit[ch]) begin
                        m_curr_addr[ch]  = m_base_addr[ch];
                        m_curr_count[ch] = m_base_count[ch];
                    end else begin
                        m_curr_addr[ch]  = m_temp_addr;
                        m_curr_count[ch] = m_temp_count;
                    end
                end
                if (tc_now) begin
                    m_tcs[ch] = 1'b1;
                    m_temp_valid = 0;
                end
            end
            if (cpu_ch >= 0) begin
                shift = m_bpff ? 8 : 0;
                mask  = 255 << shift;
                if (A_in % 2 == 1) begin
                    m_base_count[cpu_ch] = (m_base_count[cpu_ch] & ~mask) | (int'(DB_in) << shift);
                    m_curr_count[cpu_ch] = (m_curr_count[cpu_ch] & ~mask) | (int'(DB_in) << shift);
                    m_tcs[cpu_ch] = 1'b0;
                end else begin
                    m_base_addr[cpu_ch] = (m_base_addr[cpu_ch] & ~mask) | (int'(DB_in) << shift);
                    m_curr_addr[cpu_ch] = (m_curr_addr[cpu_ch] & ~mask) | (int'(DB_in) << shift);
                end
                m_bpff = !m_bpff;
            end else if (wr && A_in == 4'hC) begin
                m_bpff = 0;
            end
        end
        m_prev_iow = RESET ? 1'b1 : IOW_N;
    endtask

    task automatic checkOutput(input string tag);
        bit exp_tc;
        bit exp_carry;
        exp_tc = m_temp_valid && (m_temp_count == 0);
        exp_carry = m_temp_valid && (AddrDec[m_temp_ch] ? (m_temp_addr % 256 == 0) : (m_temp_addr % 256 == 255));
        check_val({tag, ".upper"}, {8'h00, UpperAddr}, 16'(m_upper));
        check_val({tag, ".lower"}, {8'h00, LowerAddr}, 16'(m_lower));
        check_val({tag, ".tc"}, {15'h0, TC}, {15'h0, exp_tc});
        check_val({tag, ".carry"}, {15'h0, Carry}, {15'h0, exp_carry});
        check_val({tag, ".tcstatus"}, {12'h0, TCStatus}, {12'h0, m_tcs});
    endtask

    task automatic applyStimulus(input string tag);
        model_step();
        @(posedge CLOCK);
        @(negedge CLOCK);
        checkOutput(tag);
    endtask

    task automatic idle_inputs();
        CS_N = 1; IOW_N = 1; A_in = 4'h0; DB_in = 8'h00;
        ldTempAddr = 0; AddrGen = 0; enAddrUp = 0; enAddrLo = 0;
    endtask

    task automatic cpu_write(input logic [3:0] a, input logic [7:0] d);
        CS_N = 0; IOW_N = 0; A_in = a; DB_in = d;
        applyStimulus("wr");
        CS_N = 1; IOW_N = 1;
        applyStimulus("wr_rel");
    endtask

    task automatic pulse(input string tag, input bit ld, input bit ag, input bit en, input logic [1:0] ch);
        ldTempAddr = ld; AddrGen = ag; enAddrUp = en; enAddrLo = en; ActiveChannel = ch;
        applyStimulus(tag);
        ldTempAddr = 0; AddrGen = 0; enAddrUp = 0; enAddrLo = 0;
    endtask

    initial begin
        RESET = 1; AddrDec = 4'h0; AutoInit = 4'h0; ActiveChannel = 2'd0;
        idle_inputs();
        applyStimulus("reset0");
        applyStimulus("reset1");
        check_val("reset_outputs", {UpperAddr, LowerAddr}, 16'h0000);
        check_val("reset_flags", {10'h0, TC, Carry, TCStatus}, 16'h0000);
        RESET = 0;
        applyStimulus("post_reset");

        // Channel 1 increments across the upper-byte boundary and hits TC
        cpu_write(4'hC, 8'h00);
        cpu_write(4'h2, 8'hFF); cpu_write(4'h2, 8'h12);
        cpu_write(4'h3, 8'h01); cpu_write(4'h3, 8'h00);
        pulse("ch1_load", 1, 0, 0, 2'd1);
        check_val("ch1_carry", {15'h0, Carry}, 16'h0001);
        pulse("ch1_gen1", 0, 1, 0, 2'd1);
        check_val("ch1_tc_set", {15'h0, TC}, 16'h0001);
        pulse("ch1_drive", 0, 0, 1, 2'd1);
        check_val("ch1_addr", {UpperAddr, LowerAddr}, 16'h1300);
        pulse("ch1_gen2", 0, 1, 0, 2'd1);
        check_val("ch1_tcstatus", {12'h0, TCStatus}, 16'h0002);
        check_val("ch1_tc_clear", {15'h0, TC}, 16'h0000);

        // Channel 0 decrements below 0x0100 with a zero count
        AddrDec = 4'b0001;
        cpu_write(4'hC, 8'h00);
        cpu_write(4'h0, 8'h00); cpu_write(4'h0, 8'h01);
        cpu_write(4'h1, 8'h00); cpu_write(4'h1, 8'h00);
        pulse("ch0_load", 1, 0, 0, 2'd0);
        check_val("ch0_carry_tc", {14'h0, Carry, TC}, 16'h0003);
        pulse("ch0_gen", 0, 1, 0, 2'd0);
        check_val("ch0_tcstatus", {15'h0, TCStatus[0]}, 16'h0001);
        pulse("ch0_reload", 1, 0, 0, 2'd0);
        check_val("ch0_count_wrapped", {15'h0, TC}, 16'h0000);
        pulse("ch0_drive", 0, 0, 1, 2'd0);
        check_val("ch0_curr_addr", {UpperAddr, LowerAddr}, 16'h00FF);

        // Channel 2 auto-initialises after its third transfer
        AutoInit = 4'b0100;
        cpu_write(4'hC, 8'h00);
        cpu_write(4'h4, 8'h00); cpu_write(4'h4, 8'hA0);
        cpu_write(4'h5, 8'h02); cpu_write(4'h5, 8'h00);
        pulse("ch2_load", 1, 0, 0, 2'd2);
        pulse("ch2_gen1", 0, 1, 0, 2'd2);
        pulse("ch2_gen2", 0, 1, 0, 2'd2);
        check_val("ch2_tc_third", {15'h0, TC}, 16'h0001);
        pulse("ch2_gen3", 0, 1, 0, 2'd2);
        check_val("ch2_tcstatus", {12'h0, TCStatus}, 16'h0007);
        pulse("ch2_reload", 1, 0, 0, 2'd2);
        pulse("ch2_drive", 0, 0, 1, 2'd2);
        check_val("ch2_addr_restored", {UpperAddr, LowerAddr}, 16'hA000);
        pulse("ch2_gen4", 0, 1, 0, 2'd2);
        pulse("ch2_gen5", 0, 1, 0, 2'd2);
        check_val("ch2_count_restored", {15'h0, TC}, 16'h0001);

        // A long strobe writes only once
        cpu_write(4'hC, 8'h00);
        CS_N = 0; IOW_N = 0; A_in = 4'h0; DB_in = 8'h34;
        for (int i = 0; i < 5; i++) applyStimulus("long_strobe");
        CS_N = 1; IOW_N = 1;
        applyStimulus("long_rel");
        cpu_write(4'h0, 8'h56);
        pulse("long_load", 1, 0, 0, 2'd0);
        pulse("long_drive", 0, 0, 1, 2'd0);
        check_val("long_strobe_addr", {UpperAddr, LowerAddr}, 16'h5634);

        // Channel 3 wraps 0xFFFF -> 0x0000; load and advance together only loads
        AddrDec = 4'h0; AutoInit = 4'h0;
        cpu_write(4'hC, 8'h00);
        cpu_write(4'h6, 8'hFF); cpu_write(4'h6, 8'hFF);
        cpu_write(4'h7, 8'h05); cpu_write(4'h7, 8'h00);
        pulse("ch3_load", 1, 0, 0, 2'd3);
        pulse("ch3_drive1", 0, 0, 1, 2'd3);
        check_val("ch3_ffff", {UpperAddr, LowerAddr}, 16'hFFFF);
        pulse("ch3_gen", 0, 1, 0, 2'd3);
        pulse("ch3_drive2", 0, 0, 1, 2'd3);
        check_val("ch3_wrap", {UpperAddr, LowerAddr}, 16'h0000);
        pulse("ch3_ld_and_gen", 1, 1, 0, 2'd3);
        pulse("ch3_drive3", 0, 0, 1, 2'd3);
        check_val("ch3_no_advance", {UpperAddr, LowerAddr}, 16'h0000);
        check_val("ch3_tcstatus_kept", {12'h0, TCStatus}, 16'h0007);

        // Master clear in the middle of a transfer
        pulse("mc_load", 1, 0, 0, 2'd3);
        pulse("mc_gen", 0, 1, 1, 2'd3);
        CS_N = 0; IOW_N = 0; A_in = 4'hD; DB_in = 8'h00;
        applyStimulus("mc");
        check_val("mc_outputs", {UpperAddr, LowerAddr}, 16'h0000);
        check_val("mc_flags", {10'h0, TC, Carry, TCStatus}, 16'h0000);
        CS_N = 1; IOW_N = 1;
        applyStimulus("mc_rel");
        for (int c = 0; c < 4; c++) begin
            pulse("mc_chk_load", 1, 0, 0, 2'(c));
            pulse("mc_chk_drive", 0, 0, 1, 2'(c));
        end

        // Randomised traffic against the model
        for (int i = 0; i < 400; i++) begin
            RESET         = ($urandom_range(0, 49) == 0);
            CS_N          = ($urandom_range(0, 9) < 3);
            IOW_N         = $urandom_range(0, 1) == 1;
            A_in          = 4'($urandom_range(0, 15));
            DB_in         = 8'($urandom);
            ActiveChannel = 2'($urandom);
            ldTempAddr    = ($urandom_range(0, 5) == 0);
            AddrGen       = $urandom_range(0, 1) == 1;
            enAddrUp      = $urandom_range(0, 1) == 1;
            enAddrLo      = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 15) == 0) begin
                AddrDec  = 4'($urandom);
                AutoInit = 4'($urandom);
            end
            applyStimulus("random");
        end
        RESET = 0;
        idle_inputs();
        applyStimulus("final");

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/addr_count_gen.md
ADDR_COUNT_GEN -- requirements
Module: addr_count_gen

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; ports: CLOCK in 1 (system clock, all state on posedge); RESET in 1 (synchronous, active-high).
REQ-002 CS_N in 1 (chip select, active-low); IOW_N in 1 (CPU register write strobe, active-low); A_in in 4 (register address); DB_in in 8 (CPU write data).
REQ-003 ActiveChannel in 2 (channel being serviced); ldTempAddr in 1 (load working registers); AddrGen in 1 (advance address/count); enAddrUp in 1 (drive upper address byte); enAddrLo in 1 (drive lower address byte).
REQ-004 AddrDec in 4 (per-channel: 1 = decrement address, 0 = increment); AutoInit in 4 (per-channel auto-initialize enable).
REQ-005 UpperAddr out 8 (A15:A8, strobed externally by ADSTB); LowerAddr out 8 (A7:A0); TC out 1 (terminal count, combinational); Carry out 1 (upper-byte change look-ahead, combinational); TCStatus out 4 (per-channel sticky TC flags).

Function
REQ-006 Per channel n (0..3), the block SHALL hold 16-bit BaseAddr, BaseCount, CurrAddr, CurrCount; plus 16-bit TempAddr, TempCount, 2-bit TempCh, 1-bit TempValid, and 1-bit byte-pointer flip-flop BPFF.
REQ-007 A CPU write SHALL occur only in the cycle where CS_N==0, IOW_N==0 and IOW_N was 1 in the previous cycle (one write per strobe, regardless of strobe length).
REQ-008 Write decode: A_in[3]==0 and A_in[0]==0 -> address of channel A_in[2:1]; A_in[3]==0 and A_in[0]==1 -> count of channel A_in[2:1]; 4'hC -> clear BPFF; 4'hD -> master clear; other addresses ignored.
REQ-009 Address/count writes SHALL load DB_in into the low byte when BPFF==0 and the high byte when BPFF==1, into both Base and Curr registers, then toggle BPFF.
REQ-010 A count write SHALL clear TCStatus[n] of the addressed channel.
REQ-011 Master clear SHALL have the same effect as RESET.
REQ-012 ldTempAddr==1: TempAddr<=CurrAddr[ActiveChannel], TempCount<=CurrCount[ActiveChannel], TempCh<=ActiveChannel, TempValid<=1.
REQ-013 AddrGen==1 (and ldTempAddr==0): TempAddr<=TempAddr+1 if AddrDec[TempCh]==0, else TempAddr-1, both modulo 2^16; TempCount<=TempCount-1 modulo 2^16 (0000 -> FFFF).
REQ-014 The same AddrGen cycle SHALL write the new TempAddr/TempCount back into CurrAddr/CurrCount[TempCh].
REQ-015 TC SHALL equal TempValid && TempCount==16'h0000 (programmed count N yields N+1 transfers).
REQ-016 On AddrGen with TC==1: TCStatus[TempCh]<=1 and TempValid<=0. If AutoInit[TempCh]==1, CurrAddr/CurrCount[TempCh] SHALL be reloaded from Base instead of the REQ-014 write-back.
REQ-017 Carry SHALL equal TempValid && ((AddrDec[TempCh]==0 && TempAddr[7:0]==8'hFF) || (AddrDec[TempCh]==1 && TempAddr[7:0]==8'h00)).
REQ-018 enAddrUp==1: UpperAddr<=TempAddr[15:8]. enAddrLo==1: LowerAddr<=TempAddr[7:0]. Otherwise both outputs SHALL hold; enables SHALL sample TempAddr as registered before any same-cycle AddrGen update.
REQ-019 Precedence: RESET > master clear > ldTempAddr > AddrGen. A CPU write to a channel SHALL take priority over the same-cycle AddrGen write-back or auto-init reload for that channel; the Temp update SHALL still occur.
REQ-020 ldTempAddr and AddrGen asserted together: load only; no advance, no TCStatus change.

Reset
REQ-021 On RESET all Base/Curr/Temp registers, TempCh, TempValid, BPFF, UpperAddr, LowerAddr and TCStatus SHALL be 0; therefore TC=0 and Carry=0.
REQ-022 RESET mid-transfer SHALL abandon the transfer with no write-back; CPU writes are ignored while RESET==1.

Verification
REQ-023 Program ch1 address 0x12FF, count 0x0001 (writes to A_in 2,2,3,3 after 4'hC); ldTempAddr with ActiveChannel=1; Carry=1; AddrGen -> TempAddr=0x1300, TC=1; AddrGen -> TCStatus=4'b0010, TC=0.
REQ-024 Ch0 AddrDec=1, address 0x0100, count 0x0000: after load Carry=1, TC=1; one AddrGen -> CurrAddr0=0x00FF, CurrCount0=0xFFFF, TCStatus[0]=1.
REQ-025 Ch2 AutoInit=1, base 0xA000, count 0x0002: three AddrGen pulses -> TC on third, CurrAddr2=0xA000, CurrCount2=0x0002 restored.
REQ-026 IOW_N held low 5 cycles writing 0x34 to A_in 0: only the low byte is written; BPFF=1; next strobe with 0x56 -> BaseAddr0=0x5634.
REQ-027 Address 0xFFFF increment with enAddrUp/enAddrLo: outputs 0xFF/0xFF, then after AddrGen wraps -> 0x00/0x00; ldTempAddr+AddrGen together -> no advance.
REQ-028 Master clear (A_in=4'hD) mid-transfer -> all registers and outputs 0, TC=0, TCStatus=0.
